fphub_div: RTL and testbench

Iterative divider for the custom HUB floating-point format (sign, E-bit exponent, M-bit stored mantissa, implicit leading one and implicit ILSB), producing Z = X / Y. It is the inverse-operation companion of the HUB multiplier and shares its operand format, exponent bias (2^(E-1)) and start/finish handshake. Special operands (±0, ±∞, ±1) resolve in one cycle. Normal operands go through a restoring radix-2 mantissa divider, one quotient bit per cycle.

---
 rtl/fphub_div_pkg.sv | 40 ++++
 rtl/fphub_div_special.sv | 87 ++++++++
 rtl/fphub_div.sv | 203 ++++++++++++++++++++
 tb/tb_fphub_div.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fphub_div_pkg.sv
// Shared definitions for the HUB floating-point divider.
// HUB word layout: {sign, exponent[E-1:0], stored mantissa[M-1:0]}.
// Both the implicit leading one and the implicit ILSB are excluded from the stored mantissa.
// Contents:
//   - format widths
//   - exponent bias and saturation limit
//   - ZERO/INF magnitude encodings
//   - FSM state enum
//   - special-case code enum, shared with the HUB multiplier
package fphub_pkg;

    localparam int FP_E    = 8;
    localparam int FP_M    = 23;
    localparam int FP_W    = FP_E + FP_M + 1;
    localparam int BIAS    = 2 ** (FP_E - 1);
    localparam int EXP_MAX = 2 ** FP_E - 1;

    // Magnitude encodings (sign excluded); the sign is attached by the producer.
    localparam logic [FP_W-2:0] ZERO = {{FP_E{1'b0}}, {FP_M{1'b0}}};
    localparam logic [FP_W-2:0] INF  = {{FP_E{1'b1}}, {FP_M{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NORM = 2'd2
    } div_state_e;

    // Ordered by detector priority. Y_ZERO comes before X_ZERO so that 0/0 is reported as a
    // zero divisor. X_ONE is reported for the multiplier's benefit; the divider ignores it.
    typedef enum logic [2:0] {
        SC_NONE   = 3'd0,
        SC_Y_ZERO = 3'd1,
        SC_X_ZERO = 3'd2,
        SC_X_INF  = 3'd3,
        SC_Y_INF  = 3'd4,
        SC_Y_ONE  = 3'd5,
        SC_X_ONE  = 3'd6
    } special_e;

endpackage

// File: rtl/fphub_div_special.sv
// Special-operand handling for the HUB divider.
// special_cases_detector
//   Classifies an operand pair. Shared with the multiplier.
//   Ports: x, y (HUB operands) -> code (special_e).
// special_result_for_divider
//   Maps a code onto the divider's result.
//   Ports: code, sign (x sign ^ y sign), x_mag (x without sign) -> is_special, result.
module special_cases_detector
    import fphub_pkg::*;
(
    input  logic [FP_W-1:0] x,
    input  logic [FP_W-1:0] y,
    output special_e        code
);

    logic [FP_E-1:0] x_exp;
    logic [FP_E-1:0] y_exp;
    logic [FP_M-1:0] x_mant;
    logic [FP_M-1:0] y_mant;

    assign x_exp  = x[FP_W-2:FP_M];
    assign y_exp  = y[FP_W-2:FP_M];
    assign x_mant = x[FP_M-1:0];
    assign y_mant = y[FP_M-1:0];

    // Priority classification. An exponent field of zero means zero; all ones means infinity.
    // Exponent equal to the bias with an empty mantissa means one.
    always_comb begin
        code = SC_NONE;
        if (y_exp == {FP_E{1'b0}}) begin
            code = SC_Y_ZERO;
        end else if (x_exp == {FP_E{1'b0}}) begin
            code = SC_X_ZERO;
        end else if (x_exp == {FP_E{1'b1}}) begin
            code = SC_X_INF;
        end else if (y_exp == {FP_E{1'b1}}) begin
            code = SC_Y_INF;
        end else if ((y_exp == FP_E'(BIAS)) && (y_mant == {FP_M{1'b0}})) begin
            code = SC_Y_ONE;
        end else if ((x_exp == FP_E'(BIAS)) && (x_mant == {FP_M{1'b0}})) begin
            code = SC_X_ONE;
        end else begin
            code = SC_NONE;
        end
    end

endmodule

module special_result_for_divider
    import fphub_pkg::*;
(
    input  special_e        code,
    input  logic            sign,
    input  logic [FP_W-2:0] x_mag,
    output logic            is_special,
    output logic [FP_W-1:0] result
);

    // Special-case table. A numerator of +-1 is deliberately left to the normal path.
    always_comb begin
        is_special = 1'b0;
        result     = {sign, ZERO};
        case (code)
            SC_Y_ZERO, SC_X_INF: begin
                is_special = 1'b1;
                result     = {sign, INF};
            end
            SC_X_ZERO, SC_Y_INF: begin
                is_special = 1'b1;
                result     = {sign, ZERO};
            end
            SC_Y_ONE: begin
                is_special = 1'b1;
                result     = {sign, x_mag};
            end
            SC_X_ONE, SC_NONE: begin
                is_special = 1'b0;
                result     = {sign, ZERO};
            end
            default: begin
                is_special = 1'b0;
                result     = {sign, ZERO};
            end
        endcase
    end

endmodule

// File: rtl/fphub_div.sv
// Iterative HUB floating-point divider, Z = X / Y.
// Special operands resolve in the first cycle after start.
// Normal operands use a restoring radix-2 mantissa divider that produces one quotient bit per
// cycle, followed by one normalisation cycle.
// Ports:
//   clk      rising-edge clock
//   rst_l    asynchronous reset, active high
//   start    request, honoured only when busy is low
//   X, Y     dividend and divisor (HUB format)
//   Z        registered quotient, held until the next result
//   finish   one-cycle pulse while Z holds a fresh result
//   busy     high while an operation is in flight
module fphub_div
    import fphub_pkg::*;
(
    input  logic            clk,
    input  logic            rst_l,
    input  logic            start,
    input  logic [FP_W-1:0] X,
    input  logic [FP_W-1:0] Y,
    output logic [FP_W-1:0] Z,
    output logic            finish,
    output logic            busy
);

    localparam int M     = FP_M;
    localparam int E     = FP_E;
    localparam int CNT_W = $clog2(M + 4);

    localparam logic [CNT_W-1:0]  cnt_one_c   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  cnt_zero_c  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  cnt_last_c  = CNT_W'(M + 2);
    localparam logic signed [E+1:0] bias_c    = (E + 2)'(BIAS);
    localparam logic signed [E+1:0] one_c     = (E + 2)'(1);
    localparam logic signed [E+1:0] exp_max_c = (E + 2)'(EXP_MAX);
    localparam logic signed [E+1:0] exp_zero_c = (E + 2)'(0);

    div_state_e       state_r;
    div_state_e       state_next;
    logic [FP_W-1:0]  x_r;
    logic [FP_W-1:0]  y_r;
    logic [M+2:0]     rem_r;
    logic [M+2:0]     q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [FP_W-1:0]  z_r;
    logic             finish_r;
    logic             busy_r;

    special_e         code;
    logic             is_special;
    logic [FP_W-1:0]  special_z;
    logic             sign;
    logic [M+1:0]     my;
    logic [M+3:0]     trial;
    logic             q_bit;
    logic [M+2:0]     rem_sel;
    logic [M+2:0]     rem_next;
    logic signed [E+1:0] ex;
    logic signed [E+1:0] ey;
    logic signed [E+1:0] exp_diff;
    logic signed [E+1:0] exp_norm;
    logic [M-1:0]     mant_norm;
    logic [FP_W-1:0]  norm_z;

    assign Z      = z_r;
    assign finish = finish_r;
    assign busy   = busy_r;
    assign sign   = x_r[FP_W-1] ^ y_r[FP_W-1];

    special_cases_detector u_detect (
        .x    (x_r),
        .y    (y_r),
        .code (code)
    );

    special_result_for_divider u_special (
        .code       (code),
        .sign       (sign),
        .x_mag      (x_r[FP_W-2:0]),
        .is_special (is_special),
        .result     (special_z)
    );

    // One restoring step.
    // The remainder stays below 2*my, so the bit shifted out of the top is always zero.
    always_comb begin
        my       = {1'b1, y_r[M-1:0], 1'b1};
        trial    = {1'b0, rem_r} - {2'b00, my};
        q_bit    = ~trial[M+3];
        rem_sel  = q_bit ? trial[M+2:0] : rem_r;
        rem_next = rem_sel << 1;
    end

    // Normalise the quotient, then saturate the exponent to signed INF or signed ZERO.
    // Truncation is the round-to-nearest for HUB.
    always_comb begin
        ex       = {2'b00, x_r[FP_W-2:M]};
        ey       = {2'b00, y_r[FP_W-2:M]};
        exp_diff = ex - ey + bias_c;
        if (q_r[M+2]) begin
            exp_norm  = exp_diff;
            mant_norm = q_r[M+1:2];
        end else begin
            exp_norm  = exp_diff - one_c;
            mant_norm = q_r[M:1];
        end
        if (exp_norm >= exp_max_c) begin
            norm_z = {sign, INF};
        end else if (exp_norm <= exp_zero_c) begin
            norm_z = {sign, ZERO};
        end else begin
            norm_z = {sign, exp_norm[E-1:0], mant_norm};
        end
    end

    // Next-state logic.
    // The first CALC cycle also classifies the latched operands; a special pair returns to IDLE
    // from that cycle.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CALC;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                if ((cnt_r == cnt_zero_c) && is_special) begin
                    state_next = ST_IDLE;
                end else if (cnt_r == cnt_last_c) begin
                    state_next = ST_NORM;
                end else begin
                    state_next = ST_CALC;
                end
            end
            ST_NORM: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            x_r      <= {FP_W{1'b0}};
            y_r      <= {FP_W{1'b0}};
            rem_r    <= {(M + 3){1'b0}};
            q_r      <= {(M + 3){1'b0}};
            cnt_r    <= cnt_zero_c;
            z_r      <= {FP_W{1'b0}};
            finish_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    finish_r <= 1'b0;
                    if (start) begin
                        x_r    <= X;
                        y_r    <= Y;
                        rem_r  <= {1'b0, 1'b1, X[M-1:0], 1'b1};
                        q_r    <= {(M + 3){1'b0}};
                        cnt_r  <= cnt_zero_c;
                        busy_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if ((cnt_r == cnt_zero_c) && is_special) begin
                        z_r      <= special_z;
                        finish_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        rem_r    <= rem_next;
                        q_r      <= {q_r[M+1:0], q_bit};
                        cnt_r    <= cnt_r + cnt_one_c;
                        finish_r <= 1'b0;
                    end
                end
                ST_NORM: begin
                    z_r      <= norm_z;
                    finish_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fphub_div.sv
// Directed testbench for fphub_div. Expected values are hand-computed HUB quotients.
module tb_fphub_div;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] Z;
    logic        finish;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fphub_div dut (
        .clk    (clk),
        .rst_l  (rst_l),
        .start  (start),
        .X      (X),
        .Y      (Y),
        .Z      (Z),
        .finish (finish),
        .busy   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Counts edges until finish is seen (bounded), noting whether busy stayed high before it.
    task automatic wait_finish(output int n, output logic seen, output logic busy_ok);
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (finish === 1'b1) seen = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z_exp,
                          input int lat_exp, input string tag);
        int   n;
        logic seen;
        logic bok;
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_finish(n, seen, bok);
        chk({tag, "_latency"}, 32'(n), 32'(lat_exp));
        chk({tag, "_z"}, Z, z_exp);
        chk({tag, "_busy_at_finish"}, 32'(busy), 32'd0);
        chk({tag, "_busy_between"}, 32'(bok), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_finish_pulse"}, 32'(finish), 32'd0);
        chk({tag, "_z_hold"}, Z, z_exp);
    endtask

    initial begin
        int   n;
        int   extra;
        logic seen;
        logic bok;

        rst_l = 1'b1;
        start = 1'b0;
        X = 32'h0000_0000;
        Y = 32'h0000_0000;
        #1;
        chk("reset_z", Z, 32'h0000_0000);
        chk("reset_finish", 32'(finish), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b0;

        // Normal path
        run_op(32'h40C0_0000, 32'h4040_0000, 32'h4080_0000, 27, "equal_mant");
        run_op(32'h4000_0000, 32'h4040_0000, 32'h3FAA_AAAA, 27, "ratio_lt1");
        run_op(32'hC0C0_0000, 32'h4080_0000, 32'hC03F_FFFF, 27, "ratio_gt1");
        run_op(32'hFF40_0000, 32'h00C0_0000, 32'hFF80_0000, 27, "ovf_inf");
        run_op(32'h00C0_0000, 32'hFF40_0000, 32'h8000_0000, 27, "unf_zero");

        // Special path
        run_op(32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 1, "neg_div_zero");
        run_op(32'h40C0_0000, 32'hC000_0000, 32'hC0C0_0000, 1, "div_by_one");
        run_op(32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 1, "zero_num");
        run_op(32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1, "inf_inf");
        run_op(32'h40C0_0000, 32'h7F80_0000, 32'h0000_0000, 1, "div_by_inf");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 1, "zero_zero");

        // Start while busy is ignored
        @(negedge clk);
        X = 32'h40C0_0000;
        Y = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                X = 32'h4000_0000;
                Y = 32'h4040_0000;
                start = 1'b1;
            end else if (n == 6) begin
                start = 1'b0;
                X = 32'h0000_0000;
                Y = 32'h0000_0000;
            end
            if (finish === 1'b1) seen = 1'b1;
        end
        chk("ignored_latency", 32'(n), 32'd27);
        chk("ignored_z", Z, 32'h4080_0000);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1) extra++;
        end
        chk("ignored_no_extra_finish", 32'(extra), 32'd0);

        // Start held high through the finish cycle: back-to-back
        @(negedge clk);
        X = 32'hFF40_0000;
        Y = 32'h00C0_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        X = 32'hC0C0_0000;
        Y = 32'h4080_0000;
        wait_finish(n, seen, bok);
        chk("b2b_first_latency", 32'(n), 32'd27);
        chk("b2b_first_z", Z, 32'hFF80_0000);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        chk("b2b_second_no_finish", 32'(finish), 32'd0);
        wait_finish(n, seen, bok);
        chk("b2b_second_latency", 32'(n), 32'd27);
        chk("b2b_second_z", Z, 32'hC03F_FFFF);

        // Reset in the middle of CALC
        @(negedge clk);
        X = 32'h40C0_0000;
        Y = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_l = 1'b1;
        #1;
        chk("midrst_z", Z, 32'h0000_0000);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_finish", 32'(finish), 32'd0);
        @(negedge clk);
        rst_l = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (finish === 1'b1 || busy === 1'b1) extra++;
        end
        chk("midrst_no_finish", 32'(extra), 32'd0);
        run_op(32'h4000_0000, 32'h4040_0000, 32'h3FAA_AAAA, 27, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
